// File: rtl/inta_master_pkg.sv
// Shared types and OCW2 command constants for the PIC interrupt-acknowledge initiator.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2,
    DELIVER,
    RECOVER
  } ack_state_t;

  localparam logic [7:0] OCW2_NONSPEC_EOI     = 8'h20;
  localparam logic [2:0] OCW2_SPEC_EOI_PREFIX = 3'b011;

  // Build the OCW2 byte for a specific or non-specific end-of-interrupt.
  function automatic logic [7:0] eoi_command(input logic specific, input logic [2:0] level);
    return specific ? {OCW2_SPEC_EOI_PREFIX, 2'b00, level} : OCW2_NONSPEC_EOI;
  endfunction

endpackage

// File: rtl/inta_master_if.sv
// PIC-side and core-side signals of the interrupt-acknowledge initiator.
interface inta_master_if;
  logic       int_request;
  logic       int_enable;
  logic       interrupt_acknowledge_n;
  logic [7:0] data_bus_in;
  logic       vector_valid;
  logic [7:0] vector;
  logic       vector_ready;
  logic       eoi_request;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       write_n;
  logic       a0;
  logic [7:0] data_bus_out;
  logic       data_bus_oe;
  logic       eoi_busy;

  modport master (
    input  int_request, int_enable, data_bus_in, vector_ready,
           eoi_request, eoi_specific, eoi_level,
    output interrupt_acknowledge_n, vector_valid, vector,
           write_n, a0, data_bus_out, data_bus_oe, eoi_busy
  );

  modport slave (
    output int_request, int_enable, data_bus_in, vector_ready,
           eoi_request, eoi_specific, eoi_level,
    input  interrupt_acknowledge_n, vector_valid, vector,
           write_n, a0, data_bus_out, data_bus_oe, eoi_busy
  );
endinterface

// File: rtl/inta_master_sync.sv
// N-stage flip-flop synchroniser for a single asynchronous bit.
module pic_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (reset) sync_reg <= '0;
    else       sync_reg <= {sync_reg[STAGES-2:0], din};
  end

  assign dout = sync_reg[STAGES-1];

endmodule

// File: rtl/inta_master.sv
// CPU-side INTA initiator: two-pulse acknowledge, vector capture and core handshake.
// Optional EOI command writer is built when INTA_MASTER_EOI_EN is defined.
module inta_master
  import pic_pkg::*;
#(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2,
  parameter int INT_SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          reset,
  inta_master_if.master bus
);

  localparam int LG_MAX  = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
  localparam int CNT_MAX = (LG_MAX > INT_SYNC_STAGES + 1) ? LG_MAX : INT_SYNC_STAGES + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ack_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             inta_n_reg;
  logic [7:0]       vector_reg;
  logic             vector_valid_reg;
  logic             int_sync;
  logic             ack_start;

  pic_sync #(.STAGES(INT_SYNC_STAGES)) u_int_sync (
    .clk  (clk),
    .reset(reset),
    .din  (bus.int_request),
    .dout (int_sync)
  );

`ifdef INTA_MASTER_EOI_EN
  logic             eoi_busy_reg;
  logic             eoi_writing_reg;
  logic             write_n_reg;
  logic             data_bus_oe_reg;
  logic [7:0]       eoi_cmd_reg;
  logic [7:0]       data_bus_out_reg;
  logic [CNT_W-1:0] eoi_cnt_reg;
  logic             eoi_start;

  assign ack_start = int_sync & bus.int_enable & ~eoi_writing_reg;
`else
  assign ack_start = int_sync & bus.int_enable;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      inta_n_reg       <= 1'b1;
      vector_reg       <= 8'h00;
      vector_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (ack_start) begin
          state_reg  <= ACK1;
          inta_n_reg <= 1'b0;
          cnt_reg    <= CNT_W'(INTA_LOW_CYCLES - 1);
        end
        ACK1: if (cnt_reg == '0) begin
          state_reg  <= GAP;
          inta_n_reg <= 1'b1;
          cnt_reg    <= CNT_W'(INTA_GAP_CYCLES - 1);
        end else cnt_reg <= cnt_reg - 1'b1;
        GAP: if (cnt_reg == '0) begin
          state_reg  <= ACK2;
          inta_n_reg <= 1'b0;
          cnt_reg    <= CNT_W'(INTA_LOW_CYCLES - 1);
        end else cnt_reg <= cnt_reg - 1'b1;
        ACK2: if (cnt_reg == '0) begin
          state_reg        <= DELIVER;
          inta_n_reg       <= 1'b1;
          vector_reg       <= bus.data_bus_in;
          vector_valid_reg <= 1'b1;
        end else cnt_reg <= cnt_reg - 1'b1;
        // Recovery masks the stale synchronised INT while the PIC drops it.
        DELIVER: if (bus.vector_ready) begin
          state_reg        <= RECOVER;
          vector_valid_reg <= 1'b0;
          cnt_reg          <= CNT_W'(INT_SYNC_STAGES);
        end
        RECOVER: if (cnt_reg == '0) state_reg <= IDLE;
                 else cnt_reg <= cnt_reg - 1'b1;
        default: begin
          state_reg        <= IDLE;
          inta_n_reg       <= 1'b1;
          vector_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.interrupt_acknowledge_n = inta_n_reg;
  assign bus.vector                  = vector_reg;
  assign bus.vector_valid            = vector_valid_reg;

`ifdef INTA_MASTER_EOI_EN
  // The write only starts where INTA is guaranteed high for its whole duration.
  assign eoi_start = eoi_busy_reg & ~eoi_writing_reg &
                     (((state_reg == IDLE) & ~ack_start) | (state_reg == DELIVER));

  always_ff @(posedge clk) begin
    if (reset) begin
      eoi_busy_reg     <= 1'b0;
      eoi_writing_reg  <= 1'b0;
      write_n_reg      <= 1'b1;
      data_bus_oe_reg  <= 1'b0;
      eoi_cmd_reg      <= 8'h00;
      data_bus_out_reg <= 8'h00;
      eoi_cnt_reg      <= '0;
    end else begin
      if (!eoi_busy_reg && bus.eoi_request) begin
        eoi_busy_reg <= 1'b1;
        eoi_cmd_reg  <= eoi_command(bus.eoi_specific, bus.eoi_level);
      end
      if (eoi_start) begin
        eoi_writing_reg  <= 1'b1;
        write_n_reg      <= 1'b0;
        data_bus_oe_reg  <= 1'b1;
        data_bus_out_reg <= eoi_cmd_reg;
        eoi_cnt_reg      <= CNT_W'(INTA_LOW_CYCLES - 1);
      end else if (eoi_writing_reg) begin
        if (eoi_cnt_reg == '0) begin
          eoi_writing_reg  <= 1'b0;
          eoi_busy_reg     <= 1'b0;
          write_n_reg      <= 1'b1;
          data_bus_oe_reg  <= 1'b0;
          data_bus_out_reg <= 8'h00;
        end else eoi_cnt_reg <= eoi_cnt_reg - 1'b1;
      end
    end
  end

  assign bus.write_n      = write_n_reg;
  assign bus.a0           = 1'b0;
  assign bus.data_bus_out = data_bus_out_reg;
  assign bus.data_bus_oe  = data_bus_oe_reg;
  assign bus.eoi_busy     = eoi_busy_reg;
`else
  logic unused_eoi;
  assign unused_eoi       = ^{bus.eoi_request, bus.eoi_specific, bus.eoi_level};
  assign bus.write_n      = 1'b1;
  assign bus.a0           = 1'b0;
  assign bus.data_bus_out = 8'h00;
  assign bus.data_bus_oe  = 1'b0;
  assign bus.eoi_busy     = 1'b0;
`endif

endmodule
